// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bus: station requests in, CDB broadcast and completion pulses out.
// master = reservation-station side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int N_RS   = 3,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic                           Stall;
    logic [N_RS-1:0]                Req;
    logic [N_RS-1:0][DATA_W-1:0]    Result;
    logic [N_RS-1:0][TAG_W-1:0]     R_target;
    logic                           Cdb_valid;
    logic [TAG_W-1:0]               Cdb_tag;
    logic [DATA_W-1:0]              Cdb_value;
    logic [TAG_W-1:0]               Cdb_rtarget;
    logic [N_RS-1:0]                Finished;

    modport master (
        output Stall, Req, Result, R_target,
        input  Cdb_valid, Cdb_tag, Cdb_value, Cdb_rtarget, Finished
    );

    modport slave (
        input  Stall, Req, Result, R_target,
        output Cdb_valid, Cdb_tag, Cdb_value, Cdb_rtarget, Finished
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: one registered broadcast per cycle, with a one-edge
// cooldown on the last winner so a station can drop Req after Finished without a double grant.
module cdb_arbiter #(
    parameter int N_RS   = 3,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1;
    localparam logic [DATA_W-1:0] NO_VALUE = DATA_W'(16'hFFF0);

    logic [PTR_W-1:0] rr_ptr;
    logic [N_RS-1:0]  cooldown;
    logic [N_RS-1:0]  eligible;
    logic [N_RS-1:0]  win_onehot;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             grant;
    int               idx;

    // Rotating search starting at rr_ptr; first eligible station wins.
    always_comb begin
        eligible   = bus.Req & ~cooldown;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
        win_onehot = '0;
        for (int i = 0; i < N_RS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_RS) idx = idx - N_RS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        if (found) win_onehot[win] = 1'b1;
        grant = found && !bus.Stall;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_ptr          <= '0;
            cooldown        <= '0;
            bus.Cdb_valid   <= 1'b0;
            bus.Cdb_tag     <= '0;
            bus.Cdb_value   <= NO_VALUE;
            bus.Cdb_rtarget <= '0;
            bus.Finished    <= '0;
        end else if (grant) begin
            bus.Cdb_valid   <= 1'b1;
            bus.Cdb_tag     <= TAG_W'(win) + TAG_W'(1);
            bus.Cdb_value   <= bus.Result[win];
            bus.Cdb_rtarget <= bus.R_target[win];
            bus.Finished    <= win_onehot;
            rr_ptr          <= (win == PTR_W'(N_RS - 1)) ? '0 : win + PTR_W'(1);
            cooldown        <= win_onehot;
        end else begin
            // Idle and stall edges look the same on the bus; rr_ptr holds.
            bus.Cdb_valid   <= 1'b0;
            bus.Cdb_tag     <= '0;
            bus.Cdb_value   <= NO_VALUE;
            bus.Cdb_rtarget <= '0;
            bus.Finished    <= '0;
            cooldown        <= '0;
        end
    end
endmodule
